// File: rtl/inc16.sv
// inc16 -- 16-bit combinational incrementer.
//
// Ports:
//   in  [15:0]  operand
//   out [15:0]  in + 1, wrapping 16'hFFFF to 16'h0000 (carry out discarded)
module inc16 (
  input  logic [15:0] in,
  output logic [15:0] out
);

  // The 16-bit result width truncates the carry, which gives the wrap.
  assign out = in + 16'h0001;

endmodule

// File: rtl/mux16.sv
// mux16 -- 16-bit 2:1 selector, the basic steering gate of the datapath.
//
// Ports:
//   a   [15:0]  value passed through when sel = 0
//   b   [15:0]  value passed through when sel = 1
//   sel         select line
//   out [15:0]  selected value (purely combinational)
module mux16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sel,
  output logic [15:0] out
);

  assign out = sel ? b : a;

endmodule

// File: rtl/register16.sv
// register16 -- sixteen load-enabled 1-bit registers sharing one clock and
// one load enable.
//
// Ports:
//   clk          rising-edge clock
//   load         when high, every bit captures its input at the edge
//   in  [15:0]   value to capture
//   out [15:0]   stored value, driven straight from the flops
//
// The register has no reset of its own; a clearing value is steered onto
// in by the surrounding logic when a reset is wanted.
module register16 (
  input  logic        clk,
  input  logic        load,
  input  logic [15:0] in,
  output logic [15:0] out
);

  for (genvar i = 0; i < 16; i++) begin : g_bit
    bit_reg u_bit (
      .clk  (clk),
      .load (load),
      .in   (in[i]),
      .out  (out[i])
    );
  end

endmodule

// bit_reg -- single load-enabled storage bit.
//
// Ports:
//   clk   rising-edge clock
//   load  capture enable
//   in    data bit
//   out   stored bit
module bit_reg (
  input  logic clk,
  input  logic load,
  input  logic in,
  output logic out
);

  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples the pre-edge values of its neighbours, whatever the block order.
  // NOTE: no reset term here on purpose -- the clearing value arrives on in
  // through the zero-forcing selector upstream, keeping the storage plain.
  always_ff @(posedge clk) begin
    if (load) begin
      out <= in;
    end
  end

endmodule

// File: rtl/pc.sv
// pc -- 16-bit program counter.
//
// Ports:
//   clk          rising-edge clock; the only point where out changes
//   reset        synchronous, active-high; forces out to 0 at the edge
//   in   [15:0]  value loaded when load = 1
//   load         load in at the edge (beats inc)
//   inc          add one at the edge when neither reset nor load
//   out  [15:0]  current count, taken directly from the register
//
// Priority at each edge: reset > load > inc > hold. The next value is built
// from a chain of three selectors, lowest priority first, so the last stage
// in the chain has the final say:
//   stage 1: held value vs. out + 1        (inc)
//   stage 2: stage 1    vs. in             (load)
//   stage 3: stage 2    vs. 16'h0000       (reset)
// The register is always enabled; "hold" is simply re-loading out.
module pc (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        inc,
  output logic [15:0] out
);

  logic [15:0] out_plus1;
  logic [15:0] inc_sel;
  logic [15:0] load_sel;
  logic [15:0] next_val;

  inc16 u_inc (
    .in  (out),
    .out (out_plus1)
  );

  mux16 u_mux_inc (
    .a   (out),
    .b   (out_plus1),
    .sel (inc),
    .out (inc_sel)
  );

  mux16 u_mux_load (
    .a   (inc_sel),
    .b   (in),
    .sel (load),
    .out (load_sel)
  );

  mux16 u_mux_reset (
    .a   (load_sel),
    .b   (16'h0000),
    .sel (reset),
    .out (next_val)
  );

  // Load tied high: the register captures next_val on every edge, so out
  // only ever changes at a rising clk edge and has no path from the inputs.
  register16 u_reg (
    .clk  (clk),
    .load (1'b1),
    .in   (next_val),
    .out  (out)
  );

endmodule

// File: doc/pc.md
PC -- requirements
Module: pc

Interface
REQ-001 Parameters: none; datapath width fixed at 16 bits, matching the 16-bit word of the other gates.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 in  input  16  value to load into the counter.
REQ-005 load  input  1  when high, next value = in.
REQ-006 inc  input  1  when high (and no reset/load), next value = out + 1.
REQ-007 out  output  16  current program-counter value, driven directly from internal register (registered output).

Function
REQ-008 The block SHALL update once per rising clk edge with priority reset > load > inc > hold.
REQ-009 reset=1 at an edge SHALL set out to 16'h0000 regardless of load, inc, in.
REQ-010 reset=0, load=1 SHALL set out to in at that edge, ignoring inc.
REQ-011 reset=0, load=0, inc=1 SHALL set out to (out + 1) mod 2^16.
REQ-012 reset=0, load=0, inc=0 SHALL hold out unchanged.
REQ-013 Increment SHALL wrap: out=16'hFFFF with inc SHALL yield 16'h0000, no carry/flag output.
REQ-014 Latency SHALL be exactly one cycle: inputs sampled at edge N appear on out after edge N, stable until edge N+1.
REQ-015 out SHALL be combinationally independent of in, load, inc, reset between edges (no input-to-output path).
REQ-016 Loading any 16-bit value, including 16'hFFFF and 16'h0000, SHALL be exact; a subsequent inc SHALL start from the loaded value.
REQ-017 Simultaneous load=1 and inc=1 SHALL behave identically to load=1, inc=0.
REQ-018 The next-state selection SHALL be built from the existing 16-bit 2:1 selector (one stage choosing increment vs held value, one choosing in, one forcing zero), not behavioural if/else.

Reset
REQ-019 Reset SHALL be synchronous; asserting reset between edges SHALL not change out until the next rising edge.
REQ-020 Reset asserted mid-count SHALL return out to 16'h0000 at the next edge; counting resumes from 0 on the first edge after reset deasserts with inc=1.
REQ-021 Before the first reset edge out is undefined; the bench SHALL not check out prior to reset.

Structure
REQ-022 No shared package; the 16-bit width SHALL be the only constant and is literal in port declarations, consistent with the other 16-bit gates.
REQ-023 One sub-module is natural: register16 (16 load-enabled 1-bit registers, clk, load, in[15:0], out[15:0]); pc SHALL instantiate register16 with load tied high, an inc16 adder, and three mux16 stages.
REQ-024 inc16 SHALL be combinational (out = in + 1 mod 2^16); it and register16 are separate files under the gates/sequential directories respectively.

Verification
REQ-025 reset=1 for one edge -> out=16'h0000; then inc=1 for 3 edges -> out = 0001, 0002, 0003.
REQ-026 load=1, in=16'h1234, inc=1 same edge -> out=16'h1234; next edge inc=1 only -> 16'h1235.
REQ-027 load in=16'hFFFF, then inc=1 one edge -> out=16'h0000 (wrap).
REQ-028 out=16'h0010, load=0, inc=0 for 5 edges with in toggling randomly -> out stays 16'h0010.
REQ-029 out=16'h00FF counting, reset=1 with load=1, in=16'hABCD same edge -> out=16'h0000; reset pulse changing mid-cycle without an edge -> no change.
REQ-030 Random 1000-cycle run against a reference model of REQ-008..013 -> zero mismatches, checked after each edge.
